// File: rtl/time_keeper.sv
// Digital clock (HH:MM:SS) with button-driven time setting, auto-repeat and 12/24-hour display.
// Time is kept internally as 24-hour BCD; every output is registered one cycle behind that state.
module time_keeper #(
    parameter int TICKS_PER_SEC = 12000000,
    parameter int REPEAT_TICKS  = 2097152
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       set_time,
    input  logic       position_bt,
    input  logic       change_bt,
    input  logic       mode12,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic [1:0] pos,
    output logic       editing,
    output logic       blink,
    output logic       mid_dot,
    output logic       sec_tick
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int RW = $clog2(REPEAT_TICKS);

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TICKS - 1);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] pre_r, pre_s;
    logic [RW-1:0] rep_r, rep_s;
    logic [1:0]    pos_r, pos_s;
    logic [3:0]    hr_tens_r, hr_tens_s, hr_ones_r, hr_ones_s;
    logic [3:0]    mn_tens_r, mn_tens_s, mn_ones_r, mn_ones_s;
    logic [3:0]    sc_tens_r, sc_tens_s, sc_ones_r, sc_ones_s;
    logic          tick_r, tick_s;
    logic          set_prev_r, pos_prev_r, chg_prev_r;

    logic          set_rise_s, pos_rise_s, chg_rise_s;
    logic          pos_held_s, chg_held_s, rep_fire_s;
    logic          pos_act_s, chg_act_s, wrap_s;
    logic [3:0]    disp_tens_s, disp_ones_s;
    logic          pm_s;

    assign set_rise_s = set_time & ~set_prev_r;
    assign pos_rise_s = position_bt & ~pos_prev_r;
    assign chg_rise_s = change_bt & ~chg_prev_r;
    assign pos_held_s = position_bt & pos_prev_r;
    assign chg_held_s = change_bt & chg_prev_r;
    // A fresh press restarts the repeat interval, so it also suppresses a repeat due that cycle
    assign rep_fire_s = (rep_r == REP_MAX) & ~(pos_rise_s | chg_rise_s);
    assign pos_act_s  = pos_rise_s | (pos_held_s & rep_fire_s);
    assign chg_act_s  = chg_rise_s | (chg_held_s & rep_fire_s);
    assign wrap_s     = (pre_r == PRE_MAX);

    // State register: button history, FSM, prescaler, repeat counter and time of day
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_RUN;
            pre_r      <= {PW{1'b0}};
            rep_r      <= {RW{1'b0}};
            pos_r      <= 2'd0;
            hr_tens_r  <= 4'd0;
            hr_ones_r  <= 4'd0;
            mn_tens_r  <= 4'd0;
            mn_ones_r  <= 4'd0;
            sc_tens_r  <= 4'd0;
            sc_ones_r  <= 4'd0;
            tick_r     <= 1'b0;
            set_prev_r <= 1'b0;
            pos_prev_r <= 1'b0;
            chg_prev_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pre_r      <= pre_s;
            rep_r      <= rep_s;
            pos_r      <= pos_s;
            hr_tens_r  <= hr_tens_s;
            hr_ones_r  <= hr_ones_s;
            mn_tens_r  <= mn_tens_s;
            mn_ones_r  <= mn_ones_s;
            sc_tens_r  <= sc_tens_s;
            sc_ones_r  <= sc_ones_s;
            tick_r     <= tick_s;
            set_prev_r <= set_time;
            pos_prev_r <= position_bt;
            chg_prev_r <= change_bt;
        end
    end

    // Next state: seconds counting in RUN, digit editing with auto-repeat in EDIT
    always_comb begin
        state_s   = state_r;
        pos_s     = pos_r;
        rep_s     = {RW{1'b0}};
        tick_s    = 1'b0;
        hr_tens_s = hr_tens_r;
        hr_ones_s = hr_ones_r;
        mn_tens_s = mn_tens_r;
        mn_ones_s = mn_ones_r;
        sc_tens_s = sc_tens_r;
        sc_ones_s = sc_ones_r;
        if (wrap_s) begin
            pre_s = {PW{1'b0}};
        end else begin
            pre_s = pre_r + PRE_ONE;
        end

        case (state_r)
            ST_RUN: begin
                if (set_rise_s) begin
                    state_s = ST_EDIT;
                    pos_s   = 2'd0;
                end else if (wrap_s) begin
                    tick_s = 1'b1;
                    if (sc_ones_r == 4'd9) begin
                        sc_ones_s = 4'd0;
                        if (sc_tens_r == 4'd5) begin
                            sc_tens_s = 4'd0;
                            if (mn_ones_r == 4'd9) begin
                                mn_ones_s = 4'd0;
                                if (mn_tens_r == 4'd5) begin
                                    mn_tens_s = 4'd0;
                                    if ((hr_tens_r == 4'd2) && (hr_ones_r == 4'd3)) begin
                                        hr_tens_s = 4'd0;
                                        hr_ones_s = 4'd0;
                                    end else if (hr_ones_r == 4'd9) begin
                                        hr_ones_s = 4'd0;
                                        hr_tens_s = hr_tens_r + 4'd1;
                                    end else begin
                                        hr_ones_s = hr_ones_r + 4'd1;
                                    end
                                end else begin
                                    mn_tens_s = mn_tens_r + 4'd1;
                                end
                            end else begin
                                mn_ones_s = mn_ones_r + 4'd1;
                            end
                        end else begin
                            sc_tens_s = sc_tens_r + 4'd1;
                        end
                    end else begin
                        sc_ones_s = sc_ones_r + 4'd1;
                    end
                end else begin
                    tick_s = 1'b0;
                end
            end
            ST_EDIT: begin
                if (set_rise_s) begin
                    state_s   = ST_RUN;
                    sc_tens_s = 4'd0;
                    sc_ones_s = 4'd0;
                    pre_s     = {PW{1'b0}};
                end else begin
                    if (pos_rise_s | chg_rise_s) begin
                        rep_s = {RW{1'b0}};
                    end else if (pos_held_s | chg_held_s) begin
                        if (rep_r == REP_MAX) begin
                            rep_s = {RW{1'b0}};
                        end else begin
                            rep_s = rep_r + REP_ONE;
                        end
                    end else begin
                        rep_s = {RW{1'b0}};
                    end

                    if (pos_act_s) begin
                        pos_s = pos_r + 2'd1;
                    end else if (chg_act_s) begin
                        case (pos_r)
                            2'd0: begin
                                if (hr_tens_r == 4'd2) begin
                                    hr_tens_s = 4'd0;
                                end else if (hr_tens_r == 4'd1) begin
                                    hr_tens_s = 4'd2;
                                    if (hr_ones_r > 4'd3) begin
                                        hr_ones_s = 4'd3;
                                    end else begin
                                        hr_ones_s = hr_ones_r;
                                    end
                                end else begin
                                    hr_tens_s = 4'd1;
                                end
                            end
                            2'd1: begin
                                if (hr_tens_r == 4'd2) begin
                                    hr_ones_s = (hr_ones_r >= 4'd3) ? 4'd0 : hr_ones_r + 4'd1;
                                end else begin
                                    hr_ones_s = (hr_ones_r >= 4'd9) ? 4'd0 : hr_ones_r + 4'd1;
                                end
                            end
                            2'd2: mn_tens_s = (mn_tens_r >= 4'd5) ? 4'd0 : mn_tens_r + 4'd1;
                            2'd3: mn_ones_s = (mn_ones_r >= 4'd9) ? 4'd0 : mn_ones_r + 4'd1;
                            default: pos_s = pos_r;
                        endcase
                    end else begin
                        pos_s = pos_r;
                    end
                end
            end
            default: state_s = ST_RUN;
        endcase
    end

    // 24-hour to 12-hour remap of the hour digits, and the PM flag
    always_comb begin
        disp_tens_s = hr_tens_r;
        disp_ones_s = hr_ones_r;
        pm_s        = (hr_tens_r == 4'd2) || ((hr_tens_r == 4'd1) && (hr_ones_r >= 4'd2));
        if (mode12) begin
            if ((hr_tens_r == 4'd0) && (hr_ones_r == 4'd0)) begin
                disp_tens_s = 4'd1;
                disp_ones_s = 4'd2;
            end else if ((hr_tens_r == 4'd1) && (hr_ones_r >= 4'd3)) begin
                disp_tens_s = 4'd0;
                disp_ones_s = hr_ones_r - 4'd2;
            end else if ((hr_tens_r == 4'd2) && (hr_ones_r <= 4'd1)) begin
                disp_tens_s = 4'd0;
                disp_ones_s = hr_ones_r + 4'd8;
            end else if (hr_tens_r == 4'd2) begin
                disp_tens_s = 4'd1;
                disp_ones_s = hr_ones_r - 4'd2;
            end else begin
                disp_tens_s = hr_tens_r;
                disp_ones_s = hr_ones_r;
            end
        end else begin
            disp_tens_s = hr_tens_r;
            disp_ones_s = hr_ones_r;
        end
    end

    // Output registers; the reset display follows mode12 so 00:00 shows as 12:00 in 12-hour mode
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            hour_tens <= {3'b000, mode12};
            hour_ones <= {2'b00, mode12, 1'b0};
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            pm        <= 1'b0;
            pos       <= 2'd0;
            editing   <= 1'b0;
            blink     <= 1'b0;
            mid_dot   <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            hour_tens <= disp_tens_s;
            hour_ones <= disp_ones_s;
            min_tens  <= mn_tens_r;
            min_ones  <= mn_ones_r;
            sec_tens  <= (state_r == ST_EDIT) ? 4'd0 : sc_tens_r;
            sec_ones  <= (state_r == ST_EDIT) ? 4'd0 : sc_ones_r;
            pm        <= pm_s;
            pos       <= pos_r;
            editing   <= (state_r == ST_EDIT);
            blink     <= (state_r == ST_EDIT) && (pre_r >= PRE_HALF);
            mid_dot   <= (state_r == ST_EDIT) || (pre_r < PRE_HALF);
            sec_tick  <= tick_r;
        end
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 12000000, CLK cycles per second (>=4, even).
REQ-002 Parameter REPEAT_TICKS, default 2097152, CLK cycles between auto-repeat steps while an edit button is held (>=2).
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 set_time  in  1  level; a rising edge toggles edit mode.
REQ-006 position_bt  in  1  level; advances the edit digit position.
REQ-007 change_bt  in  1  level; increments the selected digit.
REQ-008 mode12  in  1  1 = 12-hour display, 0 = 24-hour display.
REQ-009 hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
REQ-010 pm  out  1  1 when the internal hour is >= 12.
REQ-011 pos  out  2  edit position: 0 = hour_tens, 1 = hour_ones, 2 = min_tens, 3 = min_ones.
REQ-012 editing  out  1  edit mode active.
REQ-013 blink  out  1  blank phase for the selected digit; 0 outside edit mode.
REQ-014 mid_dot  out  1  colon indicator.
REQ-015 sec_tick  out  1  one-cycle pulse per elapsed second.

Function
REQ-016 Inputs are already synchronous to CLK; the block registers each button once for edge detection.
REQ-017 Prescaler counts 0..TICKS_PER_SEC-1 and wraps in both modes; it is cleared on exit from edit mode.
REQ-018 FSM states RUN and EDIT: a set_time rising edge moves RUN->EDIT (pos=0) and EDIT->RUN (seconds=00, prescaler=0).
REQ-019 In RUN, on prescaler wrap: sec_tick=1 for one cycle and time advances one second; seconds wrap 59->00 carrying to minutes, minutes 59->00 carrying to hours, 23:59:59->00:00:00.
REQ-020 In EDIT, time does not advance, sec_tick=0 and seconds read 00.
REQ-021 Edit action: fires on a button's rising edge, then every REPEAT_TICKS cycles while the button stays held; the repeat counter restarts on every press.
REQ-022 position_bt action: pos increments mod 4.
REQ-023 change_bt action, hour_tens: 0->1->2->0; when the result is 2 and hour_ones>3, hour_ones is forced to 3 in the same cycle.
REQ-024 change_bt action, hour_ones: 0..9 wrapping to 0, or 0..3 wrapping to 0 when hour_tens=2.
REQ-025 change_bt action, min_tens: 0..5 wrapping to 0; min_ones: 0..9 wrapping to 0.
REQ-026 Same-cycle priority: set_time edge > position_bt action > change_bt action; lower-priority actions that cycle are discarded.
REQ-027 Button actions are ignored in RUN.
REQ-028 Time is held internally as 24-hour; mode12 affects only the hour outputs: hour 0->12, 13..23->1..11, 1..12 unchanged; pm reflects the internal hour in both modes.
REQ-029 mode12 changes take effect on the next cycle's outputs without altering the internal time.
REQ-030 mid_dot: in RUN, 1 while prescaler < TICKS_PER_SEC/2, else 0; constant 1 in EDIT.
REQ-031 blink: in EDIT, 1 while prescaler >= TICKS_PER_SEC/2, else 0.
REQ-032 All outputs are registered, with one cycle of latency from internal state.

Reset
REQ-033 While reset_n=0: state RUN, time 00:00:00, prescaler 0, pos 0, repeat counter 0, button history 0; all outputs 0 except hour_tens=1 and hour_ones=2 when mode12=1.
REQ-034 Reset asserted mid-edit or mid-repeat abandons the operation immediately; after release, operation resumes in RUN.

Verification (TICKS_PER_SEC=10, REPEAT_TICKS=4)
REQ-035 Release reset, run 10 cycles -> sec_tick pulses once and the time reads 00:00:01; mid_dot is high for 5 cycles and low for 5 cycles.
REQ-036 Edit the time to 23:59, exit, run 60 s -> 00:00:00 with pm 1->0, via 23:59:59.
REQ-037 In EDIT set hour_ones=9, then press change_bt on hour_tens twice -> hour_tens=2 and hour_ones=3; next change on hour_ones -> 0.
REQ-038 Hold change_bt for 13 cycles at min_ones -> increments at cycles 0, 4, 8 and 12, min_ones=4.
REQ-039 Assert set_time, position_bt and change_bt on the same cycle from RUN -> editing=1, pos=0, digits unchanged.
REQ-040 Internal time 00:30 with mode12=1 -> display 12:30, pm=0; 13:05 -> 01:05, pm=1; toggle mode12 -> 13:05 on the next cycle.
